multireg_write_arbiter: RTL and testbench

Round-robin write arbiter and sequencer for the three-register (A/B/C) bank. Up to three requesters share the bank's single Data_Bus. The block grants one requester at a time, latches its data and destination, and drives Data_Bus plus a one-hot A_EN/B_EN/C_EN strobe for exactly one cycle. It then returns a per-requester acknowledge. It sits between the requesting agents and the register bank, and is the only driver of the bank's bus and enables.

---
 rtl/multireg_write_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_multireg_write_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multireg_write_arbiter.sv
// multireg_write_arbiter
// Round-robin write arbiter and sequencer for the A/B/C register bank.
// One requester is granted at a time. Its destination and data are latched,
// and one write cycle is driven on Data_Bus with a one-hot enable. The next
// cycle returns an acknowledge to that requester.
//
// Ports
//   Clock            rising-edge clock
//   Reset            asynchronous, active-low reset
//   req[2:0]         per-requester level request, held until acknowledged
//   dest0..dest2     per-requester destination (0=A, 1=B, 2=C, 3=invalid)
//   data0..data2     per-requester write data
//   ack[2:0]         one-cycle acknowledge to the granted requester
//   err              pulses with ack when the destination was invalid
//   busy             high while a transaction is in flight (WRITE/ACK)
//   grant_id[1:0]    index of the current or last granted requester
//   Data_Bus         write data to the bank, zero outside the write cycle
//   A_EN/B_EN/C_EN   bank write enables, at most one high
module multireg_write_arbiter #(
    parameter int unsigned DW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [2:0]    req,
    input  logic [1:0]    dest0,
    input  logic [1:0]    dest1,
    input  logic [1:0]    dest2,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    output logic [2:0]    ack,
    output logic          err,
    output logic          busy,
    output logic [1:0]    grant_id,
    output logic [DW-1:0] Data_Bus,
    output logic          A_EN,
    output logic          B_EN,
    output logic          C_EN
);

    localparam int unsigned NREQ = 3;
    localparam int unsigned IDW  = 2;

    localparam logic [IDW-1:0] DEST_INVALID = IDW'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  dest_q, dest_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   data_bus_q, data_bus_d;
    logic [2:0]      en_q, en_d;

    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  win_next_ptr;
    logic [IDW-1:0]  win_dest;
    logic [DW-1:0]   win_data;

    // Destination to one-hot {C,B,A} enable; invalid destination enables nothing.
    function automatic logic [2:0] decode_en(input logic [IDW-1:0] d);
        logic [2:0] e;
        case (d)
            IDW'(0): e = 3'b001;
            IDW'(1): e = 3'b010;
            IDW'(2): e = 3'b100;
            default: e = 3'b000;
        endcase
        return e;
    endfunction

    // Round-robin pick: search starts at the pointer and wraps mod 3.
    // Only consulted when at least one request is present.
    always_comb begin
        win_idx = IDW'(0);
        case (ptr_q)
            IDW'(1): begin
                if (req[1])      win_idx = IDW'(1);
                else if (req[2]) win_idx = IDW'(2);
                else             win_idx = IDW'(0);
            end
            IDW'(2): begin
                if (req[2])      win_idx = IDW'(2);
                else if (req[0]) win_idx = IDW'(0);
                else             win_idx = IDW'(1);
            end
            default: begin
                if (req[0])      win_idx = IDW'(0);
                else if (req[1]) win_idx = IDW'(1);
                else             win_idx = IDW'(2);
            end
        endcase
    end

    // Winner's payload and the pointer that follows it.
    always_comb begin
        win_dest     = dest0;
        win_data     = data0;
        win_next_ptr = IDW'(1);
        case (win_idx)
            IDW'(1): begin
                win_dest     = dest1;
                win_data     = data1;
                win_next_ptr = IDW'(2);
            end
            IDW'(2): begin
                win_dest     = dest2;
                win_data     = data2;
                win_next_ptr = IDW'(0);
            end
            default: begin
                win_dest     = dest0;
                win_data     = data0;
                win_next_ptr = IDW'(1);
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        dest_d     = dest_q;
        ack_d      = '0;
        err_d      = 1'b0;
        busy_d     = 1'b0;
        data_bus_d = '0;
        en_d       = 3'b000;

        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d    = WRITE;
                    ptr_d      = win_next_ptr;
                    grant_id_d = win_idx;
                    dest_d     = win_dest;
                    busy_d     = 1'b1;
                    // Bus and enable are loaded now so they appear in the WRITE cycle.
                    data_bus_d = win_data;
                    en_d       = decode_en(win_dest);
                end
            end
            WRITE: begin
                state_d = ACK;
                busy_d  = 1'b1;
                ack_d   = NREQ'(1) << grant_id_q;
                err_d   = (dest_q == DEST_INVALID);
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            dest_q     <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            data_bus_q <= '0;
            en_q       <= 3'b000;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            dest_q     <= dest_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            data_bus_q <= data_bus_d;
            en_q       <= en_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign Data_Bus = data_bus_q;
    assign A_EN     = en_q[0];
    assign B_EN     = en_q[1];
    assign C_EN     = en_q[2];

endmodule

// File: tb/tb_multireg_write_arbiter.sv
// Testbench for multireg_write_arbiter: directed stimulus pushes expected
// transactions into a scoreboard queue; a monitor pops one per ack pulse and
// compares ack/err/grant_id plus the bus and enables of the preceding cycle.
module tb_multireg_write_arbiter;

    localparam int unsigned DW = 8;

    logic          Clock;
    logic          Reset;
    logic [2:0]    req;
    logic [1:0]    dest0, dest1, dest2;
    logic [DW-1:0] data0, data1, data2;
    logic [2:0]    ack;
    logic          err;
    logic          busy;
    logic [1:0]    grant_id;
    logic [DW-1:0] Data_Bus;
    logic          A_EN, B_EN, C_EN;

    logic [2:0] en;
    assign en = {C_EN, B_EN, A_EN};

    multireg_write_arbiter #(.DW(DW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .req      (req),
        .dest0    (dest0),
        .dest1    (dest1),
        .dest2    (dest2),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .Data_Bus (Data_Bus),
        .A_EN     (A_EN),
        .B_EN     (B_EN),
        .C_EN     (C_EN)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0]    ack;
        logic          err;
        logic [1:0]    gid;
        logic [DW-1:0] bus;
        logic [2:0]    en;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [2:0] a, input logic e, input logic [1:0] g,
                        input logic [DW-1:0] b, input logic [2:0] en_exp);
        exp_t x;
        x.ack = a; x.err = e; x.gid = g; x.bus = b; x.en = en_exp;
        exp_q.push_back(x);
    endtask

    // Monitor: bus/enables of the write cycle are remembered and checked at the ack.
    logic [DW-1:0] prev_bus = '0;
    logic [2:0]    prev_en  = '0;

    always @(negedge Clock) begin
        if (Reset === 1'b1) begin
            if (en != 3'b000)
                chk("enable_onehot", 32'($countones(en)), 32'd1);
            if (ack != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("ack",          32'(ack),      32'(x.ack));
                    chk("err",          32'(err),      32'(x.err));
                    chk("grant_id",     32'(grant_id), 32'(x.gid));
                    chk("write_bus",    32'(prev_bus), 32'(x.bus));
                    chk("write_en",     32'(prev_en),  32'(x.en));
                    chk("ack_bus_zero", 32'(Data_Bus), 32'd0);
                    chk("ack_en_zero",  32'(en),       32'd0);
                    chk("ack_busy",     32'(busy),     32'd1);
                end
            end
        end
        prev_bus = Data_Bus;
        prev_en  = en;
    end

    // Wait for any ack bit in mask; returns after the ack sample. Drops req bits in drop.
    task automatic wait_ack(input logic [2:0] mask, input logic [2:0] drop,
                            input int exp_cycles, input string name);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge Clock);
            n++;
            if ((ack & mask) != 3'b000) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no ack within %0d cycles, required mask %b", name, n, mask);
        end else begin
            chk({name, "_latency"}, 32'(n), 32'(exp_cycles));
            req = req & ~(ack & drop);
        end
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_ack"},  32'(ack),      32'd0);
        chk({name, "_err"},  32'(err),      32'd0);
        chk({name, "_busy"}, 32'(busy),     32'd0);
        chk({name, "_gid"},  32'(grant_id), 32'd0);
        chk({name, "_bus"},  32'(Data_Bus), 32'd0);
        chk({name, "_en"},   32'(en),       32'd0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check_reset_state("reset");
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        req   = 3'b000;
        dest0 = 2'd0; dest1 = 2'd0; dest2 = 2'd0;
        data0 = '0;   data1 = '0;   data2 = '0;

        // Reset values
        do_reset();

        // Single write to B
        dest0 = 2'd1; data0 = 8'h5A;
        push(3'b001, 1'b0, 2'd0, 8'h5A, 3'b010);
        req = 3'b001;
        wait_ack(3'b001, 3'b001, 2, "single");
        @(negedge Clock);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // All three simultaneous after reset: grants 0,1,2 three cycles apart
        do_reset();
        dest0 = 2'd0; data0 = 8'h11;
        dest1 = 2'd1; data1 = 8'h22;
        dest2 = 2'd2; data2 = 8'h33;
        push(3'b001, 1'b0, 2'd0, 8'h11, 3'b001);
        push(3'b010, 1'b0, 2'd1, 8'h22, 3'b010);
        push(3'b100, 1'b0, 2'd2, 8'h33, 3'b100);
        req = 3'b111;
        wait_ack(3'b001, 3'b001, 2, "all3_g0");
        wait_ack(3'b010, 3'b010, 3, "all3_g1");
        wait_ack(3'b100, 3'b100, 3, "all3_g2");
        @(negedge Clock);

        // Fairness: requester 0 holds req, requester 2 joins during WRITE (pointer is 0)
        dest0 = 2'd0; data0 = 8'h40;
        dest2 = 2'd2; data2 = 8'h77;
        push(3'b001, 1'b0, 2'd0, 8'h40, 3'b001);
        push(3'b100, 1'b0, 2'd2, 8'h77, 3'b100);
        push(3'b001, 1'b0, 2'd0, 8'h40, 3'b001);
        req = 3'b001;
        @(negedge Clock);
        req[2] = 1'b1;
        wait_ack(3'b001, 3'b000, 1, "fair_g0");
        wait_ack(3'b100, 3'b100, 3, "fair_g2");
        wait_ack(3'b001, 3'b001, 3, "fair_g0b");
        @(negedge Clock);

        // Invalid destination: no enable, bus shows data, err with ack
        dest1 = 2'd3; data1 = 8'hFF;
        push(3'b010, 1'b1, 2'd1, 8'hFF, 3'b000);
        req = 3'b010;
        wait_ack(3'b010, 3'b010, 2, "invalid");
        @(negedge Clock);

        // Reset during WRITE aborts; after release pointer restarts at 0
        dest1 = 2'd0; data1 = 8'h3C;
        req = 3'b010;
        @(negedge Clock);
        chk("abort_write_en",  32'(en),       32'd1);
        chk("abort_write_bus", 32'(Data_Bus), 32'h3C);
        Reset = 1'b0;
        #1;
        check_reset_state("abort");
        @(negedge Clock);
        dest2 = 2'd1; data2 = 8'h5C;
        req   = 3'b110;
        Reset = 1'b1;
        push(3'b010, 1'b0, 2'd1, 8'h3C, 3'b001);
        push(3'b100, 1'b0, 2'd2, 8'h5C, 3'b010);
        wait_ack(3'b010, 3'b010, 2, "rereq_g1");
        wait_ack(3'b100, 3'b100, 3, "rereq_g2");
        @(negedge Clock);

        // Late data/dest change during WRITE has no effect
        dest0 = 2'd2; data0 = 8'hA5;
        push(3'b001, 1'b0, 2'd0, 8'hA5, 3'b100);
        req = 3'b001;
        @(negedge Clock);
        data0 = 8'h00;
        dest0 = 2'd3;
        wait_ack(3'b001, 3'b001, 1, "late");
        @(negedge Clock);
        @(negedge Clock);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
